// File: rtl/pcie_axi_wr_split.sv
// Splits one upstream AXI write burst at a time into downstream INCR bursts
// that never cross an MPS_BYTES-aligned boundary, then merges the downstream
// write responses into a single upstream response.
module pcie_axi_wr_split #(
    parameter int ID_W      = 6,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 256,
    parameter int MPS_BYTES = 128
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // upstream AW
    input  logic                s_awvalid_i,
    output logic                s_awready_o,
    input  logic [ID_W-1:0]     s_awid_i,
    input  logic [ADDR_W-1:0]   s_awaddr_i,
    input  logic [7:0]          s_awlen_i,
    input  logic [2:0]          s_awsize_i,
    input  logic [1:0]          s_awburst_i,
    // upstream W
    input  logic                s_wvalid_i,
    output logic                s_wready_o,
    input  logic                s_wlast_i,
    input  logic [DATA_W-1:0]   s_wdata_i,
    input  logic [DATA_W/8-1:0] s_wstrb_i,
    // upstream B
    output logic                s_bvalid_o,
    input  logic                s_bready_i,
    output logic [ID_W-1:0]     s_bid_o,
    output logic [1:0]          s_bresp_o,
    // downstream AW
    output logic                m_awvalid_o,
    input  logic                m_awready_i,
    output logic [ID_W-1:0]     m_awid_o,
    output logic [ADDR_W-1:0]   m_awaddr_o,
    output logic [7:0]          m_awlen_o,
    output logic [2:0]          m_awsize_o,
    output logic [1:0]          m_awburst_o,
    // downstream W
    output logic                m_wvalid_o,
    input  logic                m_wready_i,
    output logic                m_wlast_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    // downstream B
    input  logic                m_bvalid_i,
    output logic                m_bready_o,
    input  logic [ID_W-1:0]     m_bid_i,
    input  logic [1:0]          m_bresp_i
);

    localparam int MPS_BEATS = MPS_BYTES / 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AW_ISSUE = 3'd1,
        W_XFER   = 3'd2,
        B_WAIT   = 3'd3,
        B_RESP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [8:0]          rem_q, rem_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [6:0]          outst_q, outst_d;
    logic [1:0]          resp_q, resp_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   off_full;
    logic [8:0]          room;
    logic [8:0]          beats;
    logic                last_sub;
    logic                final_beat;
    logic                sub_done;
    logic                b_hs;
    logic                bready_int;
    logic                unused_bid;

    // Response IDs are implied by the single burst in flight.
    assign unused_bid = ^m_bid_i;

    // Beats left before the next MPS boundary bound the current sub-burst.
    always_comb begin
        off_full   = (addr_q >> 5) & ADDR_W'(MPS_BEATS - 1);
        room       = 9'(MPS_BEATS) - off_full[8:0];
        beats      = (rem_q < room) ? rem_q : room;
        last_sub   = ({1'b0, beat_cnt_q} == (beats - 9'd1));
        final_beat = last_sub && (rem_q == beats);
    end

    assign m_awid_o    = id_q;
    assign m_awaddr_o  = addr_q;
    assign m_awlen_o   = 8'(beats - 9'd1);
    assign m_awsize_o  = 3'd5;
    assign m_awburst_o = 2'd1;
    assign m_wdata_o   = s_wdata_i;
    assign m_wstrb_o   = s_wstrb_i;
    assign s_bid_o     = id_q;
    assign s_bresp_o   = (err_q && (resp_q < 2'd2)) ? 2'd2 : resp_q;

    assign bready_int  = (state_q == AW_ISSUE) || (state_q == W_XFER) || (state_q == B_WAIT);
    // A response with nothing outstanding is dropped entirely.
    assign b_hs        = bready_int && m_bvalid_i && (outst_q != 7'd0);

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        beat_cnt_d  = beat_cnt_q;
        resp_d      = resp_q;
        err_d       = err_q;
        sub_done    = 1'b0;
        s_awready_o = 1'b0;
        s_wready_o  = 1'b0;
        s_bvalid_o  = 1'b0;
        m_awvalid_o = 1'b0;
        m_wvalid_o  = 1'b0;
        m_wlast_o   = 1'b0;
        m_bready_o  = bready_int;

        case (state_q)
            IDLE: begin
                s_awready_o = 1'b1;
                if (s_awvalid_i) begin
                    id_d    = s_awid_i;
                    addr_d  = s_awaddr_i;
                    rem_d   = {1'b0, s_awlen_i} + 9'd1;
                    resp_d  = 2'd0;
                    err_d   = (s_awsize_i != 3'd5) || (s_awburst_i != 2'd1);
                    state_d = AW_ISSUE;
                end
            end
            AW_ISSUE: begin
                m_awvalid_o = 1'b1;
                if (m_awready_i) begin
                    beat_cnt_d = 8'd0;
                    state_d    = W_XFER;
                end
            end
            W_XFER: begin
                m_wvalid_o = s_wvalid_i;
                s_wready_o = m_wready_i;
                m_wlast_o  = last_sub;
                if (s_wvalid_i && m_wready_i) begin
                    if (s_wlast_i != final_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_sub) begin
                        addr_d   = (addr_q + ADDR_W'({beats, 5'b0})) & ~ADDR_W'(31);
                        rem_d    = rem_q - beats;
                        sub_done = 1'b1;
                        state_d  = final_beat ? B_WAIT : AW_ISSUE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            B_WAIT: begin
                if (outst_q == 7'd0) begin
                    state_d = B_RESP;
                end
            end
            B_RESP: begin
                s_bvalid_o = 1'b1;
                if (s_bready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (b_hs && (m_bresp_i > resp_q)) begin
            resp_d = m_bresp_i;
        end
        // Completion and response in the same cycle cancel out.
        outst_d = outst_q + {6'd0, sub_done} - {6'd0, b_hs};

        // Handshake outputs are held low for the whole time reset is asserted.
        if (!rst_ni) begin
            s_awready_o = 1'b0;
            s_wready_o  = 1'b0;
            s_bvalid_o  = 1'b0;
            m_awvalid_o = 1'b0;
            m_wvalid_o  = 1'b0;
            m_bready_o  = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            beat_cnt_q <= '0;
            outst_q    <= '0;
            resp_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            beat_cnt_q <= beat_cnt_d;
            outst_q    <= outst_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_pcie_axi_wr_split.sv
// Directed self-checking bench for pcie_axi_wr_split.
module tb_pcie_axi_wr_split;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         s_awvalid_i, s_awready_o;
    logic [5:0]   s_awid_i;
    logic [63:0]  s_awaddr_i;
    logic [7:0]   s_awlen_i;
    logic [2:0]   s_awsize_i;
    logic [1:0]   s_awburst_i;
    logic         s_wvalid_i, s_wready_o, s_wlast_i;
    logic [255:0] s_wdata_i;
    logic [31:0]  s_wstrb_i;
    logic         s_bvalid_o, s_bready_i;
    logic [5:0]   s_bid_o;
    logic [1:0]   s_bresp_o;
    logic         m_awvalid_o, m_awready_i;
    logic [5:0]   m_awid_o;
    logic [63:0]  m_awaddr_o;
    logic [7:0]   m_awlen_o;
    logic [2:0]   m_awsize_o;
    logic [1:0]   m_awburst_o;
    logic         m_wvalid_o, m_wready_i, m_wlast_o;
    logic [255:0] m_wdata_o;
    logic [31:0]  m_wstrb_o;
    logic         m_bvalid_i, m_bready_o;
    logic [5:0]   m_bid_i;
    logic [1:0]   m_bresp_i;

    int tests_run = 0;
    int tests_failed = 0;

    // Observations from the most recent burst.
    logic [63:0]  aw_addr_q[$];
    logic [7:0]   aw_len_q[$];
    logic [2:0]   aw_size_q[$];
    logic [1:0]   aw_burst_q[$];
    logic [5:0]   aw_id_q[$];
    logic [255:0] wd_q[$];
    logic [31:0]  ws_q[$];
    logic         wl_q[$];
    logic [5:0]   sb_id;
    logic [1:0]   sb_resp;
    int           sb_cnt;
    int           extra_sb;
    bit           timed_out;

    pcie_axi_wr_split #(
        .ID_W(6), .ADDR_W(64), .DATA_W(256), .MPS_BYTES(128)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awid_i(s_awid_i),
        .s_awaddr_i(s_awaddr_i), .s_awlen_i(s_awlen_i), .s_awsize_i(s_awsize_i),
        .s_awburst_i(s_awburst_i),
        .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wlast_i(s_wlast_i),
        .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
        .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bid_o(s_bid_o),
        .s_bresp_o(s_bresp_o),
        .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awid_o(m_awid_o),
        .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o), .m_awsize_o(m_awsize_o),
        .m_awburst_o(m_awburst_o),
        .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wlast_o(m_wlast_o),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
        .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bid_i(m_bid_i),
        .m_bresp_i(m_bresp_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] pat(input int b, input int tag);
        logic [31:0] w;
        w = 32'((tag << 16) | b);
        return {8{w}};
    endfunction

    task automatic idle_inputs();
        s_awvalid_i = 1'b0; s_awid_i = '0; s_awaddr_i = '0; s_awlen_i = '0;
        s_awsize_i = 3'd5; s_awburst_i = 2'd1;
        s_wvalid_i = 1'b0; s_wlast_i = 1'b0; s_wdata_i = '0; s_wstrb_i = '0;
        s_bready_i = 1'b0; m_awready_i = 1'b0; m_wready_i = 1'b0;
        m_bvalid_i = 1'b0; m_bid_i = '0; m_bresp_i = '0;
    endtask

    // Drives one upstream burst through the DUT while modelling the
    // downstream slave; records everything it sees for the caller to check.
    // wlast_at < 0 means s_wlast on the true final beat. decerr_sub selects
    // which downstream response (0-based) carries DECERR. In coincide mode a
    // pending m_b is only offered together with a downstream last beat.
    task automatic run_burst(input logic [5:0] id, input logic [63:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int wlast_at,
                             input int decerr_sub, input bit stall,
                             input bit coincide, input int tag);
        int  beat = 0, total = int'(len) + 1, pend = 0, bcnt = 0, cyc = 0;
        bit  aw_done = 0, done = 0;
        aw_addr_q.delete(); aw_len_q.delete(); aw_size_q.delete();
        aw_burst_q.delete(); aw_id_q.delete();
        wd_q.delete(); ws_q.delete(); wl_q.delete();
        sb_cnt = 0; extra_sb = 0; timed_out = 0; sb_id = '0; sb_resp = '0;
        while (!done && cyc < 4000) begin
            @(negedge clk_i);
            s_awvalid_i = !aw_done;
            s_awid_i = id; s_awaddr_i = addr; s_awlen_i = len;
            s_awsize_i = size; s_awburst_i = burst;
            s_wvalid_i = aw_done && (beat < total) && (!stall || $urandom_range(0, 3) != 0);
            s_wdata_i = pat(beat, tag);
            s_wstrb_i = {24'hFFFFFF, 8'(beat)};
            s_wlast_i = (wlast_at < 0) ? (beat == total - 1) : (beat == wlast_at);
            m_awready_i = !stall || ($urandom_range(0, 2) != 0);
            m_wready_i  = !stall || ($urandom_range(0, 2) != 0);
            s_bready_i  = !stall || ($urandom_range(0, 1) != 0);
            m_bvalid_i  = 1'b0;
            m_bid_i     = id;
            m_bresp_i   = (bcnt == decerr_sub) ? 2'd3 : 2'd0;
            #1;
            if (coincide)
                m_bvalid_i = (pend > 0) && ((m_wvalid_o && m_wready_i && m_wlast_o) || beat == total);
            else
                m_bvalid_i = (pend > 0) && (!stall || $urandom_range(0, 1) != 0);
            #1;
            if (s_awvalid_i && s_awready_o) aw_done = 1;
            if (m_awvalid_o && m_awready_i) begin
                aw_addr_q.push_back(m_awaddr_o); aw_len_q.push_back(m_awlen_o);
                aw_size_q.push_back(m_awsize_o); aw_burst_q.push_back(m_awburst_o);
                aw_id_q.push_back(m_awid_o);
            end
            if (m_bvalid_i && m_bready_o) begin pend--; bcnt++; end
            if (m_wvalid_o && m_wready_i) begin
                wd_q.push_back(m_wdata_o); ws_q.push_back(m_wstrb_o); wl_q.push_back(m_wlast_o);
                if (m_wlast_o) pend++;
            end
            if (s_wvalid_i && s_wready_o) beat++;
            if (s_bvalid_o && s_bready_i) begin
                sb_id = s_bid_o; sb_resp = s_bresp_o; sb_cnt++; done = 1;
            end
            cyc++;
        end
        if (!done) timed_out = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            idle_inputs();
            s_bready_i = 1'b1;
            #1;
            if (s_bvalid_o) extra_sb++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        s_awvalid_i = 1'b1; m_bvalid_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        tests_run++; if (s_awready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_awready got %b want 0", s_awready_o); end
        tests_run++; if ({m_awvalid_o, m_wvalid_o, s_bvalid_o, m_bready_o} !== 4'b0) begin tests_failed++; $display("FAIL reset_valids got %b want 0000", {m_awvalid_o, m_wvalid_o, s_bvalid_o, m_bready_o}); end
        idle_inputs();
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i); #1;
        tests_run++; if (s_awready_o !== 1'b1) begin tests_failed++; $display("FAIL post_reset_awready got %b want 1", s_awready_o); end
    endtask

    task automatic test_single();
        int bad = 0;
        run_burst(6'h2A, 64'h1000, 8'd3, 3'd5, 2'd1, -1, -1, 0, 0, 1);
        tests_run++; if (aw_addr_q.size() !== 1) begin tests_failed++; $display("FAIL single_aw_count got %0d want 1", aw_addr_q.size()); end
        else begin
            tests_run++; if ({aw_addr_q[0], aw_len_q[0], aw_size_q[0], aw_burst_q[0], aw_id_q[0]} !== {64'h1000, 8'd3, 3'd5, 2'd1, 6'h2A})
                begin tests_failed++; $display("FAIL single_aw got addr %h len %0d size %0d burst %0d id %h want 1000/3/5/1/2a", aw_addr_q[0], aw_len_q[0], aw_size_q[0], aw_burst_q[0], aw_id_q[0]); end
        end
        tests_run++; if (wd_q.size() !== 4) begin tests_failed++; $display("FAIL single_beats got %0d want 4", wd_q.size()); end
        foreach (wd_q[i]) if (wd_q[i] !== pat(i, 1) || ws_q[i] !== {24'hFFFFFF, 8'(i)} || wl_q[i] !== (i == 3)) bad++;
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL single_wbeats got %0d bad beats want 0", bad); end
        tests_run++; if ({timed_out, sb_cnt[3:0], sb_id, sb_resp, extra_sb[3:0]} !== {1'b0, 4'd1, 6'h2A, 2'd0, 4'd0})
            begin tests_failed++; $display("FAIL single_b got to=%0d cnt=%0d id=%h resp=%0d extra=%0d want 0/1/2a/0/0", timed_out, sb_cnt, sb_id, sb_resp, extra_sb); end
    endtask

    task automatic test_cross();
        int bad = 0;
        logic [63:0] ea[3];
        logic [7:0]  el[3];
        ea[0] = 64'h1040; ea[1] = 64'h1080; ea[2] = 64'h1100;
        el[0] = 8'd1;     el[1] = 8'd3;     el[2] = 8'd1;
        run_burst(6'h11, 64'h1040, 8'd7, 3'd5, 2'd1, -1, -1, 0, 0, 2);
        tests_run++; if (aw_addr_q.size() !== 3) begin tests_failed++; $display("FAIL cross_aw_count got %0d want 3", aw_addr_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            tests_run++; if (aw_addr_q[i] !== ea[i] || aw_len_q[i] !== el[i]) begin tests_failed++; $display("FAIL cross_aw%0d got %h/%0d want %h/%0d", i, aw_addr_q[i], aw_len_q[i], ea[i], el[i]); end
        end
        foreach (wd_q[i]) if (wd_q[i] !== pat(i, 2) || wl_q[i] !== (i == 1 || i == 5 || i == 7)) bad++;
        tests_run++; if (wd_q.size() !== 8 || bad !== 0) begin tests_failed++; $display("FAIL cross_wbeats got %0d beats %0d bad want 8 beats 0 bad", wd_q.size(), bad); end
        tests_run++; if ({timed_out, sb_cnt[3:0], sb_id, sb_resp} !== {1'b0, 4'd1, 6'h11, 2'd0})
            begin tests_failed++; $display("FAIL cross_b got to=%0d cnt=%0d id=%h resp=%0d want 0/1/11/0", timed_out, sb_cnt, sb_id, sb_resp); end
    endtask

    task automatic test_long_decerr();
        int bad = 0;
        run_burst(6'h05, 64'h0, 8'd255, 3'd5, 2'd1, -1, 9, 0, 0, 3);
        tests_run++; if (aw_addr_q.size() !== 64) begin tests_failed++; $display("FAIL long_aw_count got %0d want 64", aw_addr_q.size()); end
        foreach (aw_addr_q[i]) if (aw_addr_q[i] !== 64'(i * 128) || aw_len_q[i] !== 8'd3) bad++;
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL long_aw_fields got %0d bad want 0", bad); end
        tests_run++; if (wd_q.size() !== 256) begin tests_failed++; $display("FAIL long_beats got %0d want 256", wd_q.size()); end
        tests_run++; if ({timed_out, sb_cnt[3:0], sb_resp} !== {1'b0, 4'd1, 2'd3})
            begin tests_failed++; $display("FAIL long_b got to=%0d cnt=%0d resp=%0d want 0/1/3", timed_out, sb_cnt, sb_resp); end
    endtask

    task automatic test_bad_wlast();
        int bad = 0;
        run_burst(6'h07, 64'h2000, 8'd7, 3'd5, 2'd1, 2, -1, 0, 0, 4);
        foreach (wd_q[i]) if (wd_q[i] !== pat(i, 4) || wl_q[i] !== (i == 3 || i == 7)) bad++;
        tests_run++; if (wd_q.size() !== 8 || bad !== 0) begin tests_failed++; $display("FAIL badlast_beats got %0d beats %0d bad want 8 beats 0 bad", wd_q.size(), bad); end
        tests_run++; if ({timed_out, sb_cnt[3:0], sb_resp} !== {1'b0, 4'd1, 2'd2})
            begin tests_failed++; $display("FAIL badlast_b got to=%0d cnt=%0d resp=%0d want 0/1/2", timed_out, sb_cnt, sb_resp); end
    endtask

    task automatic test_bad_size();
        run_burst(6'h08, 64'h3000, 8'd1, 3'd4, 2'd1, -1, -1, 0, 0, 5);
        tests_run++; if (aw_addr_q.size() !== 1 || aw_size_q[0] !== 3'd5) begin tests_failed++; $display("FAIL badsize_aw got %0d aws want 1 with size 5", aw_addr_q.size()); end
        tests_run++; if ({timed_out, sb_cnt[3:0], sb_resp} !== {1'b0, 4'd1, 2'd2})
            begin tests_failed++; $display("FAIL badsize_b got to=%0d cnt=%0d resp=%0d want 0/1/2", timed_out, sb_cnt, sb_resp); end
    endtask

    task automatic test_stall_coincide();
        int bad = 0;
        run_burst(6'h3C, 64'h1040, 8'd7, 3'd5, 2'd1, -1, -1, 1, 1, 6);
        tests_run++; if (aw_addr_q.size() !== 3) begin tests_failed++; $display("FAIL stall_aw_count got %0d want 3", aw_addr_q.size()); end
        foreach (wd_q[i]) if (wd_q[i] !== pat(i, 6) || wl_q[i] !== (i == 1 || i == 5 || i == 7)) bad++;
        tests_run++; if (wd_q.size() !== 8 || bad !== 0) begin tests_failed++; $display("FAIL stall_wbeats got %0d beats %0d bad want 8 beats 0 bad", wd_q.size(), bad); end
        tests_run++; if ({timed_out, sb_cnt[3:0], sb_id, sb_resp, extra_sb[3:0]} !== {1'b0, 4'd1, 6'h3C, 2'd0, 4'd0})
            begin tests_failed++; $display("FAIL stall_b got to=%0d cnt=%0d id=%h resp=%0d extra=%0d want 0/1/3c/0/0", timed_out, sb_cnt, sb_id, sb_resp, extra_sb); end
    endtask

    task automatic test_back_to_back();
        run_burst(6'h01, 64'h10E0, 8'd2, 3'd5, 2'd1, -1, -1, 0, 0, 7);
        tests_run++; if (aw_addr_q.size() !== 2) begin tests_failed++; $display("FAIL b2b_aw_count got %0d want 2", aw_addr_q.size()); end
        else begin
            tests_run++; if ({aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]} !== {64'h10E0, 8'd0, 64'h1100, 8'd1})
                begin tests_failed++; $display("FAIL b2b_aw got %h/%0d %h/%0d want 10e0/0 1100/1", aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]); end
        end
        run_burst(6'h02, 64'h5FC0, 8'd0, 3'd5, 2'd1, -1, 0, 0, 0, 8);
        tests_run++; if (aw_addr_q.size() !== 1 || aw_len_q[0] !== 8'd0 || wl_q.size() !== 1 || wl_q[0] !== 1'b1)
            begin tests_failed++; $display("FAIL b2b_single_beat got %0d aws %0d beats want 1 aw len 0, 1 last beat", aw_addr_q.size(), wl_q.size()); end
        tests_run++; if ({timed_out, sb_cnt[3:0], sb_id, sb_resp} !== {1'b0, 4'd1, 6'h02, 2'd3})
            begin tests_failed++; $display("FAIL b2b_b got to=%0d cnt=%0d id=%h resp=%0d want 0/1/02/3", timed_out, sb_cnt, sb_id, sb_resp); end
    endtask

    task automatic test_mid_reset();
        int leaked = 0;
        @(negedge clk_i);
        idle_inputs();
        s_awvalid_i = 1'b1; s_awid_i = 6'h15; s_awaddr_i = 64'h1000; s_awlen_i = 8'd7;
        m_awready_i = 1'b1; m_wready_i = 1'b1;
        @(negedge clk_i); s_awvalid_i = 1'b0;
        @(negedge clk_i);
        for (int b = 0; b < 2; b++) begin
            s_wvalid_i = 1'b1; s_wdata_i = pat(b, 9); s_wlast_i = 1'b0;
            @(negedge clk_i);
        end
        s_wdata_i = pat(2, 9);
        rst_ni = 1'b0; m_bvalid_i = 1'b1;
        #1;
        tests_run++; if ({m_awvalid_o, m_wvalid_o, s_bvalid_o, m_bready_o, s_awready_o} !== 5'b0)
            begin tests_failed++; $display("FAIL midrst_during got %b want 00000", {m_awvalid_o, m_wvalid_o, s_bvalid_o, m_bready_o, s_awready_o}); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        tests_run++; if ({m_awvalid_o, m_wvalid_o, s_bvalid_o, s_awready_o} !== 4'b0001)
            begin tests_failed++; $display("FAIL midrst_after got %b want 0001", {m_awvalid_o, m_wvalid_o, s_bvalid_o, s_awready_o}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i); #1;
            if (m_awvalid_o || m_wvalid_o || s_bvalid_o) leaked++;
        end
        tests_run++; if (leaked !== 0) begin tests_failed++; $display("FAIL midrst_leak got %0d active cycles want 0", leaked); end
        idle_inputs();
        run_burst(6'h16, 64'h1000, 8'd3, 3'd5, 2'd1, -1, -1, 0, 0, 10);
        tests_run++; if ({timed_out, sb_cnt[3:0], sb_id, sb_resp, aw_addr_q.size() == 1, wd_q.size() == 4} !== {1'b0, 4'd1, 6'h16, 2'd0, 1'b1, 1'b1})
            begin tests_failed++; $display("FAIL midrst_recover got to=%0d cnt=%0d id=%h resp=%0d aws=%0d beats=%0d want 0/1/16/0/1/4", timed_out, sb_cnt, sb_id, sb_resp, aw_addr_q.size(), wd_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_cross();
        test_long_decerr();
        test_bad_wlast();
        test_bad_size();
        test_stall_coincide();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pcie_axi_wr_split.md
PCIE_AXI_WR_SPLIT -- requirements
Module: PCIE_AXI_WR_SPLIT

Interface
REQ-001 SHALL have parameter ID_W, default 6, AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default 64, AXI address width.
REQ-003 SHALL have parameter DATA_W, default 256, data width (32 B/beat).
REQ-004 SHALL have parameter MPS_BYTES, default 128, max payload size (4 beats); a power of two, at least 32 B and at most 4096 B.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 s_awvalid/s_awready  in/out  1/1  upstream AW handshake.
REQ-008 s_awid/s_awaddr/s_awlen/s_awsize/s_awburst  in  ID_W/ADDR_W/8/3/2  upstream AW fields.
REQ-009 s_wvalid/s_wready/s_wlast  in/out/in  1/1/1  upstream W handshake and last.
REQ-010 s_wdata/s_wstrb  in  DATA_W/DATA_W/8  upstream W payload.
REQ-011 s_bvalid/s_bready/s_bid/s_bresp  out/in/out/out  1/1/ID_W/2  upstream B.
REQ-012 m_awvalid/m_awready  out/in  1/1  downstream AW handshake, toward the PCIe slave port.
REQ-013 m_awid/m_awaddr/m_awlen/m_awsize/m_awburst  out  ID_W/ADDR_W/8/3/2  downstream AW fields.
REQ-014 m_wvalid/m_wready/m_wlast/m_wdata/m_wstrb  out/in/out/out/out  downstream W.
REQ-015 m_bvalid/m_bready/m_bid/m_bresp  in/out/in/in  downstream B.

Function
REQ-016 SHALL split each upstream write burst into downstream INCR bursts that never cross an MPS_BYTES-aligned boundary; 4 KB is therefore never crossed.
REQ-017 SHALL hold one upstream burst in flight: FSM IDLE -> AW_ISSUE -> W_XFER -> (AW_ISSUE | B_WAIT) -> B_RESP -> IDLE.
REQ-018 IDLE: s_awready=1; on handshake, capture id and addr, set remaining=s_awlen+1, set resp_acc=0 and err=0, go to AW_ISSUE.
REQ-019 SHALL set err if s_awsize!=5 or s_awburst!=1; the burst is still processed as 32 B INCR.
REQ-020 Sub-burst beats = min(remaining, MPS_BYTES/32 - addr[log2(MPS_BYTES)-1:5]); m_awlen = beats-1.
REQ-021 AW_ISSUE: m_awvalid=1 with m_awid=captured id, m_awaddr=cur addr, m_awsize=5, m_awburst=1; all fields stable until m_awready; then go to W_XFER with beat_cnt=0.
REQ-022 W_XFER: m_wvalid=s_wvalid, s_wready=m_wready, data/strb passed combinationally; m_wlast=(beat_cnt==beats-1); zero added latency.
REQ-023 On the final sub-burst beat: addr+=beats*32 with addr[4:0] cleared, remaining-=beats, outstanding+=1; go to AW_ISSUE if remaining!=0, else B_WAIT.
REQ-024 SHALL set err if s_wlast!=1 on the overall final beat, or s_wlast==1 on any earlier beat.
REQ-025 m_bready=1 in AW_ISSUE, W_XFER and B_WAIT, else 0; each m_b handshake: outstanding-=1, resp_acc=max(resp_acc,m_bresp).
REQ-026 Sub-burst completion and m_b handshake in the same cycle SHALL leave outstanding unchanged; outstanding is 7 bits (max 65).
REQ-027 B_WAIT -> B_RESP when outstanding==0; an m_b handshake at outstanding==0 is ignored.
REQ-028 B_RESP: s_bvalid=1, s_bid=captured id, s_bresp=err?max(resp_acc,2):resp_acc; held until s_bready, then IDLE.
REQ-029 s_awready=0 and s_wready=0 outside IDLE and W_XFER respectively.

Reset
REQ-030 While rst_n=0 at a clock edge: state=IDLE, counters=0, err=0, resp_acc=0.
REQ-031 While rst_n=0: outputs m_awvalid, m_wvalid, s_bvalid, m_bready=0 and s_awready=0.
REQ-032 Reset mid-burst SHALL abandon it; no further beats or responses are issued for that burst.

Verification
REQ-033 AW addr 0x1000 len 3 -> one m_aw 0x1000 len 3; m_wlast on beat 4; after m_b OKAY, s_b id echoed with OKAY.
REQ-034 AW addr 0x1040 len 7 -> m_aw 0x1040/len1, 0x1080/len3, 0x1100/len1; m_wlast on beats 2, 6, 8; one s_b only after the third m_b.
REQ-035 AW addr 0x0 len 255 -> 64 sub-bursts of len 3; DECERR on sub-burst 10, rest OKAY -> s_bresp=3.
REQ-036 s_wlast on beat 3 of an 8-beat burst -> all 8 beats forwarded, s_bresp=2.
REQ-037 Random m_awready/m_wready/s_bready stalls; m_bvalid coincident with a final sub-burst beat -> no beat lost, exactly one s_b.
REQ-038 rst_n=0 for one cycle during W_XFER -> next cycle all valids 0; after release s_awready=1 and a new burst completes normally.
